frame_sequencer: RTL
====================

# frame_sequencer

Receive-frame sequencer between the frequency-correction stage and the host-facing sample stream. It watches the corrected stream for the synchronizer's frame-detect marker, then gates exactly one frame of `frame_len` payload samples to the output, tagged with the frequency estimate latched at detection. After each frame it enforces a hold-off window and raises a one-cycle frame-done interrupt. It replaces the direct frequency_correction-to-`m_axis` connection and the raw `irq = sync_last` hookup in the wiphy top level.

## Interface
Parameters:
- `LEN_WIDTH`, 16: width of `frame_len` and of the internal sample counter.
- `HOLDOFF`, 64: number of cycles the input is discarded after a frame; must be ≥1.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level-sensitive; arms the sequencer.
- `frame_len`  in  LEN_WIDTH  payload samples per frame; sampled at detection.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  input sample accept.
- `s_data`  in  32  input sample, {Q[31:16], I[15:0]}.
- `s_user`  in  32  frequency estimate accompanying the sample.
- `s_last`  in  1  frame-detect marker: last preamble sample; payload starts with the next sample.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  output sample accept.
- `m_data`  out  32  output sample.
- `m_user`  out  32  frequency estimate latched at detection; constant for the whole frame.
- `m_last`  out  1  asserted with the final payload sample.
- `busy`  out  1  high in CAPTURE and HOLDOFF.
- `dropped`  out  8  saturating count of detects ignored (in CAPTURE/HOLDOFF, or with `frame_len == 0`).
- `irq`  out  1  one-cycle frame-done pulse.

## Operation
- Input handshake: transfer on `s_valid & s_ready`. Output handshake: transfer on `m_valid & m_ready`.
- States: IDLE, SEARCH, CAPTURE, HOLDOFF.
- **IDLE**
  - `s_ready = 1`; input is discarded.
  - Goes to SEARCH when `enable = 1`.
- **SEARCH**
  - `s_ready = 1`; input is discarded.
  - `enable = 0` → IDLE.
  - On a transfer with `s_last = 1` and `frame_len != 0`: latch `s_user` into `m_user` and `frame_len` into the counter, then go to CAPTURE.
  - On a transfer with `s_last = 1` and `frame_len == 0`: stay in SEARCH and increment `dropped`.
- **CAPTURE**
  - A one-entry registered output stage drives `m_*`.
  - `s_ready = !m_valid | m_ready`.
  - Each input transfer loads the stage and decrements the counter.
  - The load taking the counter to 0 sets `m_last`; after that, `s_ready = 0`.
  - When the `m_last` sample transfers, go to HOLDOFF.
  - `s_last` seen in CAPTURE is passed through as ordinary data and increments `dropped`.
  - Deasserting `enable` does not truncate the frame.
- **HOLDOFF**
  - `s_ready = 1`; input is discarded.
  - A down-counter runs for HOLDOFF cycles; `s_last` transfers increment `dropped`.
  - When it expires: `enable` high → SEARCH, otherwise → IDLE.
- `dropped` saturates at 255 and clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - `s_ready = 1` (combinational: IDLE state).
  - `m_valid = 0`, `m_last = 0`, `m_data = 0`, `m_user = 0`.
  - `busy = 0`, `dropped = 0`, `irq = 0`.
- Reset mid-frame abandons the frame immediately. No `m_last` and no `irq` are produced.
- Detection: the state is CAPTURE in the cycle after the `s_last` transfer. The first payload sample can be accepted in that cycle.
- Latency: 1 cycle, input transfer to `m_valid`. With `m_ready` held high, throughput is 1 sample/cycle with no bubbles.
- `m_valid`, `m_data`, `m_last` and `m_user` are held stable while `m_valid & !m_ready`.
- `irq` is high exactly in the cycle after the `m_last` output transfer. The state is HOLDOFF in that same cycle.
- HOLDOFF lasts exactly HOLDOFF cycles. Counting starts in the cycle after the `m_last` transfer, so SEARCH/IDLE is entered HOLDOFF+1 cycles after that transfer.
- `frame_len` is sampled only at detection. Changes during a frame have no effect.
- `frame_len = 1`: the first payload sample carries `m_last`.

## Test plan
- **Basic frame.** `enable=1`, `frame_len=4`, continuous input, `s_last` on sample 10 with `s_user=0x12345678`, `m_ready=1`.
  - Samples 11–14 appear one cycle delayed; `m_last` only on 14; `m_user=0x12345678` on all four.
  - `irq` pulses once, the cycle after sample 14's transfer.
  - Samples up to and including 10, and all samples after 14, are discarded.
- **Backpressure.** `frame_len=8`, `m_ready` toggling 1/0 every cycle.
  - Output is exactly 8 samples in order; no duplicates or loss.
  - Outputs are stable while stalled; `s_ready` is low whenever `m_valid & !m_ready`.
- **Ignored detects.** `HOLDOFF=16`; second `s_last` mid-frame, third 5 cycles after `irq`.
  - Neither starts a frame; `dropped=2`.
  - A fourth `s_last` after hold-off starts a new frame.
- **Enable mid-frame.** Deassert `enable` after the 2nd of 6 samples.
  - All 6 samples output with `m_last` and `irq`; state is IDLE after hold-off.
  - A later `s_last` is ignored and `dropped` is unchanged.
- **Zero length.** `frame_len=0` with an `s_last`.
  - No output; `dropped` increments; state stays SEARCH.
  - Saturation: 300 such detects → `dropped=255`.
- **Reset mid-frame.** Assert `reset` (asynchronous, between clock edges) after 3 of 10 samples.
  - All outputs take their reset values immediately; no `irq`.
  - After release with `enable=1`, a new `s_last` yields a full 10-sample frame.

Source files
------------

// File: rtl/frame_sequencer.sv
// Receive-frame sequencer: waits for the frame-detect marker, gates one frame of
// frame_len payload samples to the output, then holds off and pulses irq.
module frame_sequencer #(
    parameter int LEN_WIDTH = 16,
    parameter int HOLDOFF   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    input  logic [31:0]          s_user,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic [31:0]          m_user,
    output logic                 m_last,
    output logic                 busy,
    output logic [7:0]           dropped,
    output logic                 irq
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CAPTURE,
        ST_HOLDOFF
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [31:0]          m_data_q, m_data_d;
    logic [31:0]          m_user_q, m_user_d;
    logic                 irq_q, irq_d;
    logic [7:0]           dropped_q, dropped_d;
    logic                 m_xfer;
    logic                 drop_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        irq_d     = 1'b0;
        drop_evt  = 1'b0;
        s_ready   = 1'b1;
        m_xfer    = m_valid_q & m_ready;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (s_valid && s_last) begin
                    if (frame_len != '0) begin
                        m_user_d = s_user;
                        cnt_d    = frame_len;
                        state_d  = ST_CAPTURE;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                // Counter at zero means the final sample is already staged.
                s_ready = (cnt_q != '0) && (!m_valid_q || m_ready);
                if (m_xfer) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if (s_valid && s_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_last_d  = (cnt_q == LEN_WIDTH'(1));
                    cnt_d     = cnt_q - LEN_WIDTH'(1);
                    drop_evt  = s_last;
                end
                if (m_xfer && m_last_q) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = HOLD_W'(HOLDOFF);
                    irq_d   = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                drop_evt = s_valid & s_last;
                if (hold_q == HOLD_W'(1)) begin
                    state_d = enable ? ST_SEARCH : ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dropped_d = dropped_q;
        if (drop_evt && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            irq_q     <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            irq_q     <= irq_d;
            dropped_q <= dropped_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign m_user  = m_user_q;
    assign irq     = irq_q;
    assign dropped = dropped_q;
    assign busy    = (state_q == ST_CAPTURE) || (state_q == ST_HOLDOFF);

endmodule
